spkr_buffer_ctrl: RTL and testbench
===================================

SPKR_BUFFER_CTRL -- requirements
Module: spkr_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12: sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16: FIFO depth in samples; it SHALL be a power of two and at least 4.
REQ-003 The block SHALL have parameter LOW_MARK, default 4: refill request threshold in samples; it SHALL be less than DEPTH/2.
REQ-004 Port clk SHALL be input, width 1: the single clock; all logic is on posedge clk.
REQ-005 Port rst_n SHALL be input, width 1: synchronous, active-low reset.
REQ-006 Port wr_en SHALL be input, width 1: upstream writes wr_data this cycle.
REQ-007 Port wr_data SHALL be input, width WIDTH: sample to enqueue.
REQ-008 Port spkr_done SHALL be input, width 1: one-cycle pulse meaning the speaker consumed the current sample and needs the next.
REQ-009 Port flag_clr SHALL be input, width 1: clears the sticky underrun and overflow flags.
REQ-010 Port spkr_data SHALL be output, width WIDTH, registered: sample presented to the speaker.
REQ-011 Port spkr_update SHALL be output, width 1, registered: one-cycle pulse when spkr_data is loaded with a new sample.
REQ-012 Port refill_req SHALL be output, width 1, registered: request to upstream for more samples.
REQ-013 Port level SHALL be output, width $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
REQ-014 Port full SHALL be output, width 1: level == DEPTH.
REQ-015 Port empty SHALL be output, width 1: level == 0.
REQ-016 Port underrun SHALL be output, width 1: sticky flag.
REQ-017 Port overflow SHALL be output, width 1: sticky flag.

Function
REQ-018 The FIFO SHALL be circular, with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 Write acceptance: a write SHALL be accepted when wr_en=1 and either full=0 or a pop is accepted in the same cycle.
REQ-020 Pop acceptance: a pop SHALL be accepted when spkr_done=1 and empty=0.
REQ-021 Level update: level SHALL change by +1 on a write only, by -1 on a pop only, and SHALL stay unchanged when both or neither occur.
REQ-022 Accepted pop: spkr_data SHALL take the head sample and spkr_update SHALL pulse, both on the clock edge after spkr_done, i.e. 1-cycle latency.
REQ-023 Empty pop: when spkr_done=1 and empty=1, spkr_data SHALL hold its previous value, spkr_update SHALL stay 0, and underrun SHALL set; a write in that same cycle SHALL still be accepted.
REQ-024 Rejected write: when wr_en=1, full=1 and no pop is accepted, the write SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL set.
REQ-025 Flag clear: flag_clr=1 SHALL clear underrun and overflow on the next edge; if a set event occurs in the same cycle, set SHALL take priority.
REQ-026 Refill state machine, states IDLE and FILL, with refill_req=1 only in FILL:
  - IDLE -> FILL when the next-cycle level <= LOW_MARK.
  - FILL -> IDLE when the next-cycle level >= DEPTH-LOW_MARK.
  - Otherwise the state SHALL hold, giving hysteresis.
REQ-027 full, empty and level SHALL be derived from registered state, with no combinational path from wr_en or spkr_done.

Reset
REQ-028 When rst_n=0 at a clock edge, the following SHALL result:
  - Pointers, level, spkr_data, spkr_update, underrun and overflow all reset to 0.
  - The state machine enters FILL, so refill_req=1 and empty=1.
REQ-029 Reset SHALL override all inputs, including a mid-stream wr_en or spkr_done; FIFO storage contents need not be cleared.

Verification
REQ-030 Reset then idle: after reset release, level=0, empty=1, refill_req=1, spkr_data=0, with no spkr_update for 20 cycles.
REQ-031 Fill and hysteresis: write 12 samples 0x001..0x00C -> refill_req drops on the edge level becomes 12; pop 8 -> refill_req rises on the edge level becomes 4.
REQ-032 Pop latency and order: with FIFO holding 0x0A5,0x15A, pulse spkr_done -> next cycle spkr_data=0x0A5 with spkr_update=1; pulse again -> spkr_data=0x15A.
REQ-033 Full boundary: write 16 samples, then write 0xFFF with no pop -> overflow=1, level=16, head unchanged; write plus pop in the same cycle -> accepted, level stays 16, 0xFFF is last out.
REQ-034 Empty boundary: with level=0, pulse spkr_done and wr_en=0x123 together -> underrun=1, spkr_data unchanged, no spkr_update, level=1; flag_clr -> underrun=0.
REQ-035 Reset mid-operation: assert rst_n=0 with level=9 and spkr_done=1 -> next edge level=0, spkr_update=0, refill_req=1; pointer wrap verified by 40 streamed samples in order.

Source files
------------

// File: rtl/spkr_buffer_ctrl.sv
// Speaker sample buffer: circular FIFO feeding a speaker one sample per spkr_done,
// with sticky underrun/overflow flags and a hysteretic refill request.
module spkr_buffer_ctrl #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 16,
    parameter int LOW_MARK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     spkr_done,
    input  logic                     flag_clr,
    output logic [WIDTH-1:0]         spkr_data,
    output logic                     spkr_update,
    output logic                     refill_req,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     underrun,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_MARK);
    localparam logic [LW-1:0] HIGH_LVL  = LW'(DEPTH - LOW_MARK);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] spkr_data_q;
    logic             spkr_update_q;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    state_t           state_q, state_d;
    logic             push, pop;

    assign full  = (level_q == DEPTH_LVL);
    assign empty = (level_q == '0);

    // A write into a full FIFO is still taken when the head leaves in the same cycle.
    always_comb begin
        pop        = spkr_done && !empty;
        push       = wr_en && (!full || pop);
        level_d    = level_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (flag_clr) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (spkr_done && empty)         underrun_d = 1'b1;
        if (wr_en && full && !pop)      overflow_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (level_d <= LOW_LVL)  state_d = FILL;
            FILL:    if (level_d >= HIGH_LVL) state_d = IDLE;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            spkr_data_q   <= '0;
            spkr_update_q <= 1'b0;
            underrun_q    <= 1'b0;
            overflow_q    <= 1'b0;
            state_q       <= FILL;
        end else begin
            level_q       <= level_d;
            underrun_q    <= underrun_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            spkr_update_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                spkr_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr_q] <= wr_data;
    end

    assign spkr_data   = spkr_data_q;
    assign spkr_update = spkr_update_q;
    assign refill_req  = (state_q == FILL);
    assign level       = level_q;
    assign underrun    = underrun_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_spkr_buffer_ctrl.sv
// Bench for spkr_buffer_ctrl: directed boundary scenarios plus randomized traffic,
// all outputs checked each cycle against a queue-based model.
module tb_spkr_buffer_ctrl;
    localparam int WIDTH = 12, DEPTH = 16, LOW_MARK = 4;

    logic             clk = 1'b0;
    logic             rst_n, wr_en, spkr_done, flag_clr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] spkr_data;
    logic             spkr_update, refill_req, full, empty, underrun, overflow;
    logic [$clog2(DEPTH):0] level;

    spkr_buffer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOW_MARK(LOW_MARK)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .spkr_done(spkr_done), .flag_clr(flag_clr), .spkr_data(spkr_data),
        .spkr_update(spkr_update), .refill_req(refill_req), .level(level),
        .full(full), .empty(empty), .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the FIFO is a queue, the refill request a boolean with two thresholds.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data;
    logic             m_upd, m_under, m_over, m_req;
    bit               chk_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_data = '0; m_upd = 0; m_under = 0; m_over = 0; m_req = 1;
            chk_en = 1;
        end else if (chk_en) begin
            bit do_pop, do_push, set_u, set_o;
            int n;
            do_pop  = spkr_done && q.size() > 0;
            do_push = wr_en && (q.size() < DEPTH || do_pop);
            set_u   = spkr_done && q.size() == 0;
            set_o   = wr_en && q.size() == DEPTH && !do_pop;
            m_upd   = do_pop;
            if (do_pop)  m_data = q.pop_front();
            if (do_push) q.push_back(wr_data);
            m_under = set_u ? 1'b1 : (flag_clr ? 1'b0 : m_under);
            m_over  = set_o ? 1'b1 : (flag_clr ? 1'b0 : m_over);
            n = q.size();
            if (!m_req && n <= LOW_MARK)              m_req = 1;
            else if (m_req && n >= DEPTH - LOW_MARK)  m_req = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level",       32'(level),       32'(q.size()));
            chk("full",        32'(full),        32'(q.size() == DEPTH));
            chk("empty",       32'(empty),       32'(q.size() == 0));
            chk("spkr_data",   32'(spkr_data),   32'(m_data));
            chk("spkr_update", 32'(spkr_update), 32'(m_upd));
            chk("refill_req",  32'(refill_req),  32'(m_req));
            chk("underrun",    32'(underrun),    32'(m_under));
            chk("overflow",    32'(overflow),    32'(m_over));
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [WIDTH-1:0] d,
                       input logic dn, input logic clr);
        rst_n = r; wr_en = w; wr_data = d; spkr_done = dn; flag_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);  cyc(1, 1, d, 0, 0); endtask
    task automatic pop1();                         cyc(1, 0, '0, 1, 0); endtask

    initial begin
        int upd_cnt;
        rst_n = 0; wr_en = 0; wr_data = '0; spkr_done = 0; flag_clr = 0;
        cyc(0, 0, '0, 0, 0);
        cyc(0, 1, 12'h777, 1, 0);

        // Reset then idle
        upd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, '0, 0, 0);
            if (spkr_update) upd_cnt++;
        end
        chk("idle_level", 32'(level), 0);
        chk("idle_empty", 32'(empty), 1);
        chk("idle_req",   32'(refill_req), 1);
        chk("idle_data",  32'(spkr_data), 0);
        chk("idle_updates", upd_cnt, 0);

        // Fill and hysteresis
        for (int i = 1; i <= 11; i++) wr(WIDTH'(i));
        chk("fill11_req", 32'(refill_req), 1);
        wr(12'h00C);
        chk("fill12_level", 32'(level), 12);
        chk("fill12_req",   32'(refill_req), 0);
        for (int i = 0; i < 7; i++) pop1();
        chk("pop7_req", 32'(refill_req), 0);
        pop1();
        chk("pop8_level", 32'(level), 4);
        chk("pop8_req",   32'(refill_req), 1);
        chk("pop8_data",  32'(spkr_data), 32'h008);
        for (int i = 0; i < 4; i++) pop1();

        // Pop latency and order
        wr(12'h0A5); wr(12'h15A);
        cyc(1, 0, '0, 1, 0);
        chk("lat_data0", 32'(spkr_data), 32'h0A5);
        chk("lat_upd0",  32'(spkr_update), 1);
        cyc(1, 0, '0, 0, 0);
        chk("lat_upd_gap", 32'(spkr_update), 0);
        pop1();
        chk("lat_data1", 32'(spkr_data), 32'h15A);

        // Empty boundary
        cyc(1, 1, 12'h123, 1, 0);
        chk("emp_under", 32'(underrun), 1);
        chk("emp_data",  32'(spkr_data), 32'h15A);
        chk("emp_upd",   32'(spkr_update), 0);
        chk("emp_level", 32'(level), 1);
        cyc(1, 0, '0, 0, 1);
        chk("emp_clr", 32'(underrun), 0);
        pop1();

        // Full boundary
        for (int i = 0; i < 16; i++) wr(WIDTH'(12'h200 + i));
        chk("full_flag", 32'(full), 1);
        wr(12'hFFF);
        chk("full_over",  32'(overflow), 1);
        chk("full_level", 32'(level), 16);
        cyc(1, 1, 12'hFFF, 1, 0);
        chk("full_head",   32'(spkr_data), 32'h200);
        chk("full_level2", 32'(level), 16);
        for (int i = 0; i < 16; i++) pop1();
        chk("full_last", 32'(spkr_data), 32'hFFF);
        chk("full_drain", 32'(level), 0);
        cyc(1, 1, 12'h321, 0, 1);
        chk("clr_over", 32'(overflow), 0);
        pop1();

        // Reset mid-operation, then 40 streamed samples across several pointer wraps
        for (int i = 0; i < 9; i++) wr(WIDTH'(12'h300 + i));
        chk("mid_level", 32'(level), 9);
        cyc(0, 0, '0, 1, 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_upd",   32'(spkr_update), 0);
        chk("mid_rst_req",   32'(refill_req), 1);
        for (int i = 0; i < 40; i++) cyc(1, 1, WIDTH'(12'h400 + i), i > 0, 0);
        pop1();
        chk("stream_last", 32'(spkr_data), 32'h427);

        // Randomized traffic in phases of different write/pop bias
        for (int ph = 0; ph < 12; ph++) begin
            int wp, dp;
            wp = $urandom_range(10, 90);
            dp = $urandom_range(10, 90);
            for (int i = 0; i < 250; i++)
                cyc($urandom_range(0, 199) != 0,
                    $urandom_range(0, 99) < wp,
                    WIDTH'($urandom),
                    $urandom_range(0, 99) < dp,
                    $urandom_range(0, 19) == 0);
        end
        cyc(1, 0, '0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
